// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches to a variable-latency
// memory, buffers {pc, instruction} pairs for Fetch, and flushes on redirect.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK_50,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0]       fifo_pc_q   [DEPTH];
    logic [31:0]       fifo_inst_q [DEPTH];

    logic              head_valid;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_after_pop;
    logic [CNT_W-1:0]  count_after_push;
    logic [31:0]       redirect_target;

    assign head_valid       = (count_q != '0);
    assign pop              = head_valid && !stall_i && !redirect_i;
    assign push             = (state_q == REQ) && mem_ack_i && !redirect_i;
    assign redirect_target  = redirect_pc_i & 32'hFFFF_FFFC;
    assign count_after_pop  = count_q - CNT_W'(pop);
    assign count_after_push = count_after_pop + CNT_W'(push);

    assign inst_valid_o = head_valid;
    assign inst_o       = head_valid ? fifo_inst_q[rd_ptr_q] : '0;
    assign pc_o         = head_valid ? fifo_pc_q[rd_ptr_q] : '0;
    assign mem_req_o    = (state_q != IDLE);
    assign mem_addr_o   = mem_addr_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        count_d    = count_after_push;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

        if (redirect_i) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = redirect_target;
            // An unacked request must still complete; its data is dropped in DRAIN.
            case (state_q)
                IDLE: begin
                    state_d    = REQ;
                    mem_addr_d = redirect_target;
                end
                REQ, DRAIN: begin
                    if (mem_ack_i) begin
                        state_d    = REQ;
                        mem_addr_d = redirect_target;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_after_pop < DEPTH_C) begin
                        state_d    = REQ;
                        mem_addr_d = fetch_pc_q;
                    end
                end
                REQ: begin
                    if (mem_ack_i) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (count_after_push < DEPTH_C) begin
                            mem_addr_d = fetch_pc_q + 32'd4;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_ack_i) begin
                        state_d    = REQ;
                        mem_addr_d = fetch_pc_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_50) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge CLK_50) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= mem_addr_q;
            fifo_inst_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

endmodule
